stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-input, W-bit registered multiplexer with valid/ready on every port.
//  Successor to the fixed 4:1 single-bit mux. Adds any channel count and data width,
//  a one-entry output register, and a choice of select source: external sel or internal round-robin.
//  Sits between several producer streams and one consumer (datapath/bus staging).
// PARAMETERS
//  N     4   number of input channels, >=2 (need not be a power of two)
//  W     8   data width per channel, >=1
//  SELW  $clog2(N) (localparam, derived)  width of sel/out_sel
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_data    in   N*W    channel k occupies bits [k*W +: W]
//  in_valid   in   N      per-channel valid
//  in_ready   out  N      per-channel ready; combinational, at most one bit high
//  mode       in   1      0 = FIXED (use sel), 1 = RR (round-robin)
//  sel        in   SELW   channel select in FIXED mode
//  out_data   out  W      registered data
//  out_valid  out  1      registered valid
//  out_sel    out  SELW   channel index that produced out_data
//  out_ready  in   1      consumer ready
// BEHAVIOUR
//  - Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, last_grant=N-1.
//  - Output FSM, 2 states: EMPTY (out_valid=0) and FULL (out_valid=1).
//    load_en = !out_valid || out_ready.
//    EMPTY->FULL on grant. FULL->EMPTY on out_ready && !grant.
//    FULL->FULL on (out_ready && grant), which reloads, or on !out_ready, which holds.
//  - Grant (combinational, one-hot g[N-1:0]):
//    FIXED: g[sel] = in_valid[sel] && load_en. If sel >= N, then g = 0.
//    RR: scan channels last_grant+1, +2, ... mod N. The first valid channel is granted if load_en.
//  - in_ready = g. A transfer on channel k occurs when in_valid[k] && in_ready[k].
//  - On a grant to channel k at the clock edge: out_data <= in_data[k], out_sel <= k, last_grant <= k.
//    last_grant is updated in both modes.
//  - Latency: 1 cycle from input transfer to out_valid.
//    Throughput: 1 word/cycle while out_ready=1 and some in_valid=1.
//  - Hold: while out_valid && !out_ready, out_data and out_sel are stable and in_ready=0.
//  - mode and sel are sampled combinationally every cycle. A change affects only the next grant.
//    A word already in the register is never altered.
//  - RR fairness: a continuously valid channel is granted within N grants.
//  - Reset asserted mid-transfer: the word in the register is dropped and nothing is granted.
//    After reset release, RR priority starts at channel 0.
//  - in_valid may drop without a transfer. in_data of non-granted channels is don't-care.
// STRUCTURE
//  - Package mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1.
//  - Sub-module rr_arbiter #(N): inputs req[N], last[SELW], en.
//    Outputs grant[N] (one-hot) and grant_idx[SELW].
//    Rotate-priority search; shared with future arbiters.
//  - Top level: FIXED grant decode, mode mux onto the grant, output register/FSM, last_grant register.
// TESTING (N=4, W=8)
//  1 Reset mid-stream: assert rst with out_valid=1.
//    -> out_valid=0, out_data=0 immediately. First RR grant after release goes to channel 0.
//  2 FIXED, sel=2, in_data[2]=0xA5, in_valid=4'b0100, out_ready=1.
//    -> in_ready=4'b0100. Next cycle out_data=0xA5, out_sel=2, out_valid=1.
//  3 RR, all in_valid=1, data k=0x10+k, out_ready=1 for 8 cycles.
//    -> out_sel sequence 0,1,2,3,0,1,2,3. One word per cycle, no gaps.
//  4 Backpressure: FULL holding 0x33 with out_ready=0 for 5 cycles, in_valid=4'b1111.
//    -> in_ready=0 throughout, out_data=0x33 stable. Drains the cycle out_ready=1.
//  5 RR sparse: in_valid=4'b1001, last_grant=0.
//    -> grant channel 3, then 0, then 3 (channels 1 and 2 skipped).
//  6 FIXED with sel=1 but in_valid[1]=0 and in_valid[0]=1.
//    -> no grant, out_valid falls to 0 after drain. Mode switch to RR mid-stream affects only the next grant.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared types and constants for the registered N:1 stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ost_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority arbiter: the request nearest after 'last' (mod N) wins when enabled.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [N-1:0]    hit;
  logic [SELW-1:0] idx;
  logic [SELW-1:0] j;

  // Walk from the farthest offset to the nearest so the nearest requester overwrites.
  always_comb begin
    hit = '0;
    idx = '0;
    j   = '0;
    for (int i = N; i >= 1; i--) begin
      j = SELW'((int'(last) + i) % N);
      if (req[j]) begin
        hit    = '0;
        hit[j] = 1'b1;
        idx    = j;
      end
    end
  end

  assign grant     = en ? hit : '0;
  assign grant_idx = idx;

endmodule

// File: rtl/stream_mux_rr.sv
// N-input, W-bit registered stream mux with valid/ready; fixed-select or round-robin grant.
import mux_pkg::*;

module stream_mux_rr #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  ost_e            state_q, state_d;
  logic            load_en;
  logic            any_g;
  logic [N-1:0]    fix_g;
  logic [N-1:0]    rr_g;
  logic [N-1:0]    g;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] g_idx;
  logic [SELW-1:0] last_grant;
  logic [W-1:0]    g_data;

  assign out_valid = (state_q == ST_FULL);
  assign load_en   = !out_valid || out_ready;

  // Out-of-range sel matches no channel, so it grants nothing.
  always_comb begin
    fix_g = '0;
    for (int k = 0; k < N; k++)
      fix_g[k] = (sel == SELW'(k)) && in_valid[k] && load_en;
  end

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .last      (last_grant),
    .en        (load_en),
    .grant     (rr_g),
    .grant_idx (rr_idx)
  );

  // Nothing may transfer while reset is held.
  assign g        = rst ? '0 : ((mode == MODE_RR) ? rr_g : fix_g);
  assign g_idx    = (mode == MODE_RR) ? rr_idx : sel;
  assign any_g    = |g;
  assign in_ready = g;

  always_comb begin
    g_data = '0;
    for (int k = 0; k < N; k++)
      if (g[k]) g_data = in_data[k*W +: W];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (any_g) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !any_g) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SELW'(N - 1);
    end else begin
      state_q <= state_d;
      if (any_g) begin
        out_data   <= g_data;
        out_sel    <= g_idx;
        last_grant <= g_idx;
      end
    end
  end

endmodule
